pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter FB_BASE, default 32'h0000_0000: framebuffer byte base address.
REQ-002 SHALL have parameter FB_WIDTH, default 640: framebuffer width in pixels.
REQ-003 SHALL have parameter FB_HEIGHT, default 480: framebuffer height in pixels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: pixel buffer entries, a power of two and at least 2.
REQ-005 SHALL have port clock  input  1  sole clock; everything is synchronous to its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pixel_data  input  64  [63:48] x, [47:32] y, [31:0] colour.
REQ-008 SHALL have port pixel_data_valid  input  1  producer offers pixel_data.
REQ-009 SHALL have port pixel_fifo_full  output  1  back-pressure to the producer.
REQ-010 SHALL have port avm_address  output  32  Avalon-MM byte address.
REQ-011 SHALL have port avm_write  output  1  Avalon-MM write request.
REQ-012 SHALL have port avm_writedata  output  32  colour word.
REQ-013 SHALL have port avm_waitrequest  input  1  slave stall.
REQ-014 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-015 SHALL have port pixel_count  output  32  completed memory writes, wraps at 2^32.

Function
REQ-016 SHALL accept a beat on each edge where pixel_data_valid=1 and pixel_fifo_full=0; valid while full is ignored, and the producer holds the data.
REQ-017 SHALL drive pixel_fifo_full=1 combinationally whenever the FIFO count equals FIFO_DEPTH.
REQ-018 SHALL keep the count unchanged on a simultaneous push and pop, and write the pushed entry correctly.
REQ-019 SHALL never pop an empty FIFO; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, ADDR and WRITE.
REQ-021 SHALL go IDLE->ADDR when the FIFO is non-empty, popping the head entry into working registers.
REQ-022 SHALL in ADDR register avm_address = FB_BASE + ((y*FB_WIDTH + x) << 2), using 32-bit unsigned arithmetic and wrapping on overflow; it SHALL register avm_writedata = colour, then go to WRITE with avm_write=1.
REQ-023 SHALL in WRITE hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1.
REQ-024 SHALL on the first WRITE edge with avm_waitrequest=0 complete exactly one write, increment pixel_count, and drop avm_write.
REQ-025 SHALL after a completed write go to ADDR, popping the next entry, if the FIFO is non-empty, else to IDLE.
REQ-026 SHALL meet this latency: a push into an empty idle block at edge N gives avm_write=1 after edge N+2; with no wait states, throughput is one pixel per 2 cycles.
REQ-027 SHALL drive avm_write=0 in IDLE and ADDR.

Reset
REQ-028 SHALL on reset=1 immediately, without waiting for a clock edge: empty the FIFO, enter IDLE, and drive avm_write=0, avm_address=0, avm_writedata=0, pixel_count=0, busy=0 and pixel_fifo_full=0.
REQ-029 SHALL on reset asserted mid-WRITE abandon the write without completing it or counting it; after release, operation resumes from an empty state.

Configuration
REQ-030 SHALL, with PIXEL_WRITER_CLIP_EN defined, in ADDR discard any entry with x>=FB_WIDTH or y>=FB_HEIGHT: no write, no pixel_count change, and the next state follows REQ-025.
REQ-031 SHALL, with PIXEL_WRITER_CLIP_EN undefined, write every entry at the address given by REQ-022, including out-of-range coordinates.

Verification
REQ-032 SHALL cover: push x=3, y=2, colour 0x00FF0000 with waitrequest=0 -> one write to 0x0000140C with data 0x00FF0000, avm_write high after edge N+2, pixel_count=1.
REQ-033 SHALL cover: same pixel with waitrequest high for 3 cycles -> avm_write high for 4 cycles, address and data stable throughout, exactly one write counted.
REQ-034 SHALL cover: waitrequest held high, offer 6 pixels back-to-back -> pixel_fifo_full=1 after the 5th acceptance (1 in flight plus 4 buffered), 6th held; on release, all 6 written in order.
REQ-035 SHALL cover: push x=640, y=0 -> with PIXEL_WRITER_CLIP_EN, no write and pixel_count unchanged; without it, a write to 0x00000A00.
REQ-036 SHALL cover: assert reset during WRITE with 2 entries buffered -> avm_write=0 with no clock edge, count=0; after release, a new pixel is written normally.
REQ-037 SHALL cover: FIFO at FIFO_DEPTH-1 with a simultaneous push and completed write -> count unchanged, no loss or duplication across 20 random pixels checked against a reference queue.

Source files
------------

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffered pixel-to-framebuffer Avalon-MM writer
//
// Accepts (x, y, colour) beats into a small FIFO and turns each entry into
// one Avalon-MM write of the colour word at the pixel's linear byte address.
//
// Optional feature macro: PIXEL_WRITER_CLIP_EN
//   defined   : entries outside FB_WIDTH x FB_HEIGHT are discarded unwritten
//   undefined : every entry is written, out-of-range coordinates included
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   pixel_data            - [63:48] x, [47:32] y, [31:0] colour
//   pixel_data_valid      - producer offers pixel_data
//   pixel_fifo_full       - back-pressure, high while the FIFO holds FIFO_DEPTH
//   avm_address           - Avalon-MM byte address
//   avm_write             - Avalon-MM write request
//   avm_writedata         - colour word
//   avm_waitrequest       - slave stall
//   busy                  - FIFO non-empty or FSM not IDLE
//   pixel_count           - completed memory writes (wraps)

module pixel_writer #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          FB_WIDTH   = 640,
    parameter int          FB_HEIGHT  = 480,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] pixel_data,
    input  logic        pixel_data_valid,
    output logic        pixel_fifo_full,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic [31:0] pixel_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty;
    logic             push, pop;
    logic [63:0]      head;

    state_t           state_q;
    logic [15:0]      x_q, y_q;
    logic [31:0]      colour_q;
    logic [31:0]      addr_calc;
    logic             clip;

    assign fifo_empty      = (count_q == '0);
    assign pixel_fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push            = pixel_data_valid && !pixel_fifo_full;
    assign head            = mem_q[rd_ptr_q];

    // Pops happen only where the FSM takes a new working entry; each term
    // is gated by !fifo_empty so an empty FIFO is never popped.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                S_IDLE:  pop = 1'b1;
                S_ADDR:  pop = clip;
                S_WRITE: pop = !avm_waitrequest;
                default: pop = 1'b0;
            endcase
        end
    end

    // Simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push && pop)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= pixel_data;
    end

    // Pointers wrap modulo FIFO_DEPTH through natural overflow (power of two).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Address generation and optional clipping
    // ------------------------------------------------------------------
    assign addr_calc = FB_BASE +
                       ((32'(y_q) * 32'(FB_WIDTH) + 32'(x_q)) << 2);

`ifdef PIXEL_WRITER_CLIP_EN
    assign clip = (state_q == S_ADDR) &&
                  ((32'(x_q) >= 32'(FB_WIDTH)) || (32'(y_q) >= 32'(FB_HEIGHT)));
`else
    assign clip = 1'b0;
`endif

    assign busy = !fifo_empty || (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Write FSM with registered Avalon outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
            pixel_count   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    avm_write <= 1'b0;
                    if (pop) begin
                        {x_q, y_q, colour_q} <= head;
                        state_q              <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (clip) begin
                        // Discarded entry: move on exactly as after a write.
                        avm_write <= 1'b0;
                        if (pop) begin
                            {x_q, y_q, colour_q} <= head;
                            state_q              <= S_ADDR;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        avm_address   <= addr_calc;
                        avm_writedata <= colour_q;
                        avm_write     <= 1'b1;
                        state_q       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Outputs are held while the slave stalls.
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        pixel_count <= pixel_count + 32'd1;
                        if (pop) begin
                            {x_q, y_q, colour_q} <= head;
                            state_q              <= S_ADDR;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    avm_write <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - scoreboard testbench for pixel_writer
module tb_pixel_writer;

    localparam int FBW = 640;
    localparam int FBH = 480;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pixel_data = '0;
    logic        pixel_data_valid = 1'b0;
    logic        pixel_fifo_full;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic [31:0] pixel_count;

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] sb [$];
    int exp_count = 0;

    pixel_writer dut (
        .clock            (clock),
        .reset            (reset),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .pixel_fifo_full  (pixel_fifo_full),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (avm_waitrequest),
        .busy             (busy),
        .pixel_count      (pixel_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference address/clip model.
    task automatic model_push(input logic [15:0] x, input logic [15:0] y, input logic [31:0] c);
        logic [31:0] a;
        bit drop = 0;
`ifdef PIXEL_WRITER_CLIP_EN
        drop = (int'(x) >= FBW) || (int'(y) >= FBH);
`endif
        a = (32'(y) * 32'(FBW) + 32'(x)) << 2;
        if (!drop) begin
            sb.push_back({a, c});
            exp_count++;
        end
    endtask

    // A write completes on the coming edge when avm_write && !waitrequest.
    always @(negedge clock) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {avm_address, avm_writedata}, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("wr_addr", 64'(avm_address), 64'(e[63:32]));
                chk("wr_data", 64'(avm_writedata), 64'(e[31:0]));
            end
        end
    end

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [31:0] c,
                        input bit rnd_wr);
        int n = 0;
        bit acc = 0;
        pixel_data = {x, y, c};
        pixel_data_valid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge clock);
            acc = !pixel_fifo_full;
            @(posedge clock); #1;
            n++;
            if (rnd_wr) avm_waitrequest = 1'($urandom_range(0, 1));
        end
        pixel_data_valid = 1'b0;
        if (acc) model_push(x, y, c);
        else chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_write();
        int n = 0;
        while (!avm_write && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("write_timeout", 64'(avm_write), 64'd1);
    endtask

    initial begin
        logic [31:0] a0, d0;

        // Reset state
        #1;
        chk("rst_write", 64'(avm_write), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_data", 64'(avm_writedata), 64'd0);
        chk("rst_count", 64'(pixel_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_full", 64'(pixel_fifo_full), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Single pixel, no wait states: latency N+2
        push(16'd3, 16'd2, 32'h00FF_0000, 0);
        chk("lat_n0", 64'(avm_write), 64'd0);
        @(posedge clock); #1;
        chk("lat_n1", 64'(avm_write), 64'd0);
        @(posedge clock); #1;
        chk("lat_n2", 64'(avm_write), 64'd1);
        chk("t1_addr", 64'(avm_address), 64'h140C);
        chk("t1_data", 64'(avm_writedata), 64'h00FF_0000);
        @(posedge clock); #1;
        chk("t1_drop", 64'(avm_write), 64'd0);
        chk("t1_count", 64'(pixel_count), 64'd1);
        wait_idle();

        // Same pixel with 3 wait-state cycles
        avm_waitrequest = 1'b1;
        push(16'd3, 16'd2, 32'h00FF_0000, 0);
        wait_write();
        a0 = avm_address;
        d0 = avm_writedata;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("ws_write", 64'(avm_write), 64'd1);
            chk("ws_addr", 64'(avm_address), 64'(a0));
            chk("ws_data", 64'(avm_writedata), 64'(d0));
            chk("ws_count", 64'(pixel_count), 64'd1);
        end
        avm_waitrequest = 1'b0;
        @(posedge clock); #1;
        chk("ws_done", 64'(avm_write), 64'd0);
        chk("ws_count2", 64'(pixel_count), 64'd2);
        wait_idle();

        // Back-pressure: six pixels with waitrequest held
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++)
            push(16'(10 + i), 16'(i), 32'hA000_0000 + 32'(i), 0);
        chk("bp_full", 64'(pixel_fifo_full), 64'd1);
        pixel_data = {16'd20, 16'd7, 32'hA000_0005};
        pixel_data_valid = 1'b1;
        @(posedge clock); #1;
        chk("bp_held_full", 64'(pixel_fifo_full), 64'd1);
        chk("bp_held_count", 64'(pixel_count), 64'd2);
        avm_waitrequest = 1'b0;
        push(16'd20, 16'd7, 32'hA000_0005, 0);
        wait_idle();
        chk("bp_count", 64'(pixel_count), 64'(exp_count));
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Out-of-range x
        push(16'd640, 16'd0, 32'h1234_5678, 0);
        wait_idle();
        chk("clip_count", 64'(pixel_count), 64'(exp_count));

        // Reset during WRITE with two entries buffered
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++)
            push(16'(i), 16'd1, 32'hB000_0000 + 32'(i), 0);
        wait_write();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_write", 64'(avm_write), 64'd0);
        chk("mid_rst_count", 64'(pixel_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_full", 64'(pixel_fifo_full), 64'd0);
        chk("mid_rst_addr", 64'(avm_address), 64'd0);
        sb.delete();
        exp_count = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        push(16'd5, 16'd5, 32'hC0DE_0001, 0);
        wait_idle();
        chk("post_rst_count", 64'(pixel_count), 64'd1);

        // Simultaneous push and completed write at FIFO_DEPTH-1, then random
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++)
            push(16'($urandom_range(0, FBW - 1)), 16'($urandom_range(0, FBH - 1)), $urandom, 0);
        chk("sim_pre", 64'(dut.count_q), 64'd3);
        avm_waitrequest = 1'b0;
        push(16'($urandom_range(0, FBW - 1)), 16'($urandom_range(0, FBH - 1)), $urandom, 0);
        chk("sim_post", 64'(dut.count_q), 64'd3);
        chk("sim_wcount", 64'(pixel_count), 64'd2);
        for (int i = 0; i < 15; i++)
            push(16'($urandom_range(0, FBW - 1)), 16'($urandom_range(0, FBH - 1)), $urandom, 1);
        avm_waitrequest = 1'b0;
        wait_idle();
        chk("rnd_count", 64'(pixel_count), 64'(exp_count));
        chk("rnd_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
